// File: rtl/mem_line_interface_pkg.sv
// Shared constants for the cache-line memory interface: bus messages,
// coherence states and the line-engine state encoding.
package mem_line_interface_pkg;

    localparam int unsigned NO_REQ   = 0;
    localparam int unsigned R_REQ    = 1;
    localparam int unsigned WB_REQ   = 2;
    localparam int unsigned FLUSH    = 3;
    localparam int unsigned MEM_RESP = 10;

    localparam int unsigned INVALID   = 0;
    localparam int unsigned SHARED    = 1;
    localparam int unsigned EXCLUSIVE = 2;
    localparam int unsigned MODIFIED  = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_READ    = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    // Messages that start a line transaction when seen in IDLE.
    function automatic bit is_line_req(input int unsigned msg);
        return (msg == R_REQ) || (msg == WB_REQ) || (msg == FLUSH);
    endfunction

endpackage

// File: rtl/mem_line_interface_if.sv
// Bus bundle for mem_line_interface: cache, local memory and network channels.
// slave = the line interface itself, master = its surroundings.
interface mem_line_interface_if #(
    parameter int OFFSET_BITS   = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MSG_BITS      = 4
);
    localparam int LINE_WIDTH = DATA_WIDTH << OFFSET_BITS;

    logic [MSG_BITS-1:0]      cache2interface_msg;
    logic [ADDRESS_WIDTH-1:0] cache2interface_address;
    logic [LINE_WIDTH-1:0]    cache2interface_data;
    logic [MSG_BITS-1:0]      interface2cache_msg;
    logic [ADDRESS_WIDTH-1:0] interface2cache_address;
    logic [LINE_WIDTH-1:0]    interface2cache_data;

    logic [MSG_BITS-1:0]      mem2interface_msg;
    logic [ADDRESS_WIDTH-1:0] mem2interface_address;
    logic [DATA_WIDTH-1:0]    mem2interface_data;
    logic [MSG_BITS-1:0]      interface2mem_msg;
    logic [ADDRESS_WIDTH-1:0] interface2mem_address;
    logic [DATA_WIDTH-1:0]    interface2mem_data;

    logic [MSG_BITS-1:0]      network2interface_msg;
    logic [ADDRESS_WIDTH-1:0] network2interface_address;
    logic [DATA_WIDTH-1:0]    network2interface_data;
    logic [MSG_BITS-1:0]      interface2network_msg;
    logic [ADDRESS_WIDTH-1:0] interface2network_address;
    logic [DATA_WIDTH-1:0]    interface2network_data;

    logic                     interface_busy;

    modport slave (
        input  cache2interface_msg, cache2interface_address, cache2interface_data,
        input  mem2interface_msg, mem2interface_address, mem2interface_data,
        input  network2interface_msg, network2interface_address, network2interface_data,
        output interface2cache_msg, interface2cache_address, interface2cache_data,
        output interface2mem_msg, interface2mem_address, interface2mem_data,
        output interface2network_msg, interface2network_address, interface2network_data,
        output interface_busy
    );

    modport master (
        output cache2interface_msg, cache2interface_address, cache2interface_data,
        output mem2interface_msg, mem2interface_address, mem2interface_data,
        output network2interface_msg, network2interface_address, network2interface_data,
        input  interface2cache_msg, interface2cache_address, interface2cache_data,
        input  interface2mem_msg, interface2mem_address, interface2mem_data,
        input  interface2network_msg, interface2network_address, interface2network_data,
        input  interface_busy
    );

endinterface

// File: rtl/mem_route_select.sv
// Combinational home-node router: decides local vs network for a new request,
// steers the outbound word request to one port and selects that port's response.
module mem_route_select
    import mem_line_interface_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MSG_BITS      = 4,
    parameter int NODE_BITS     = 2,
    parameter int NODE_ID       = 0
) (
    input  logic [NODE_BITS-1:0]     req_home,
    output logic                     req_local,
    input  logic                     sel_local,
    input  logic [MSG_BITS-1:0]      out_msg,
    input  logic [ADDRESS_WIDTH-1:0] out_address,
    input  logic [DATA_WIDTH-1:0]    out_data,
    input  logic [MSG_BITS-1:0]      mem_msg,
    input  logic [ADDRESS_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    input  logic [MSG_BITS-1:0]      net_msg,
    input  logic [ADDRESS_WIDTH-1:0] net_address,
    input  logic [DATA_WIDTH-1:0]    net_data,
    output logic [MSG_BITS-1:0]      resp_msg,
    output logic [ADDRESS_WIDTH-1:0] resp_address,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic [MSG_BITS-1:0]      mem_req_msg,
    output logic [ADDRESS_WIDTH-1:0] mem_req_address,
    output logic [DATA_WIDTH-1:0]    mem_req_data,
    output logic [MSG_BITS-1:0]      net_req_msg,
    output logic [ADDRESS_WIDTH-1:0] net_req_address,
    output logic [DATA_WIDTH-1:0]    net_req_data
);

    assign req_local = (req_home == NODE_BITS'(NODE_ID));

    // The unselected port always sees an all-zero (NO_REQ) request.
    always_comb begin
        mem_req_msg     = '0;
        mem_req_address = '0;
        mem_req_data    = '0;
        net_req_msg     = '0;
        net_req_address = '0;
        net_req_data    = '0;
        if (sel_local) begin
            mem_req_msg     = out_msg;
            mem_req_address = out_address;
            mem_req_data    = out_data;
            resp_msg        = mem_msg;
            resp_address    = mem_address;
            resp_data       = mem_data;
        end else begin
            net_req_msg     = out_msg;
            net_req_address = out_address;
            net_req_data    = out_data;
            resp_msg        = net_msg;
            resp_address    = net_address;
            resp_data       = net_data;
        end
    end

endmodule

// File: rtl/mem_line_interface.sv
// Cache-line to single-word memory interface (FSM, word counter, line buffers).
// Optional feature macro: CRITICAL_WORD_FIRST_EN (reads start at the requested word).
module mem_line_interface
    import mem_line_interface_pkg::*;
#(
    parameter int OFFSET_BITS   = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MSG_BITS      = 4,
    parameter int NODE_BITS     = 2,
    parameter int NODE_ID       = 0
) (
    input logic clock,
    input logic reset,
    mem_line_interface_if.slave bus
);
    localparam int WORDS     = 1 << OFFSET_BITS;
    localparam int LINE_BITS = ADDRESS_WIDTH - OFFSET_BITS;

    logic [1:0]               state_reg, state_next;
    logic [OFFSET_BITS:0]     count_reg;
    logic [LINE_BITS-1:0]     line_reg;
    logic                     local_reg;
    logic [ADDRESS_WIDTH-1:0] cache_addr_reg;
    logic [DATA_WIDTH-1:0]    wline_reg [WORDS];
    logic [OFFSET_BITS-1:0]   start, word_idx;
    logic                     active, accept, is_read_req, word_done, last_word, req_local;
    logic [MSG_BITS-1:0]      out_msg, resp_msg;
    logic [ADDRESS_WIDTH-1:0] out_address, resp_address;
    logic [DATA_WIDTH-1:0]    out_data, resp_data;

    assign is_read_req = (bus.cache2interface_msg == MSG_BITS'(R_REQ));
    assign accept      = (state_reg == ST_IDLE) && is_line_req(32'(bus.cache2interface_msg));
    assign active      = (state_reg == ST_READ) || (state_reg == ST_WRITE);
    assign word_idx    = start + count_reg[OFFSET_BITS-1:0];
    assign last_word   = &count_reg[OFFSET_BITS-1:0];
    assign word_done   = active && (resp_msg == MSG_BITS'(MEM_RESP)) && (resp_address == out_address);

`ifdef CRITICAL_WORD_FIRST_EN
    logic [OFFSET_BITS-1:0] start_reg;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            start_reg <= '0;
        else if (accept)
            start_reg <= is_read_req ? bus.cache2interface_address[OFFSET_BITS-1:0] : '0;
    end
    assign start = start_reg;
`else
    assign start = '0;
`endif

    always_comb begin
        out_msg     = '0;
        out_address = '0;
        out_data    = '0;
        if (active) begin
            out_msg     = (state_reg == ST_READ) ? MSG_BITS'(R_REQ) : MSG_BITS'(WB_REQ);
            out_address = {line_reg, word_idx};
            if (state_reg == ST_WRITE)
                out_data = wline_reg[word_idx];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (accept) state_next = is_read_req ? ST_READ : ST_WRITE;
            ST_READ,
            ST_WRITE:   if (word_done && last_word) state_next = ST_RESPOND;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            count_reg      <= '0;
            line_reg       <= '0;
            local_reg      <= 1'b0;
            cache_addr_reg <= '0;
            for (int i = 0; i < WORDS; i++)
                wline_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                count_reg      <= '0;
                line_reg       <= bus.cache2interface_address[ADDRESS_WIDTH-1:OFFSET_BITS];
                local_reg      <= req_local;
                cache_addr_reg <= bus.cache2interface_address;
                // Write-back/flush data is captured now; the cache may drop it next cycle.
                if (!is_read_req)
                    for (int i = 0; i < WORDS; i++)
                        wline_reg[i] <= bus.cache2interface_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (word_done) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    // One read slot per word; each holds its data until a later read refills it.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : gen_slot
            logic [DATA_WIDTH-1:0] slot_reg;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)
                    slot_reg <= '0;
                else if (word_done && (state_reg == ST_READ) && (word_idx == OFFSET_BITS'(gi)))
                    slot_reg <= resp_data;
            end
            assign bus.interface2cache_data[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
        end
    endgenerate

    assign bus.interface2cache_msg     = (state_reg == ST_RESPOND) ? MSG_BITS'(MEM_RESP) : MSG_BITS'(NO_REQ);
    assign bus.interface2cache_address = (state_reg == ST_RESPOND) ? cache_addr_reg : '0;
    assign bus.interface_busy          = (state_reg != ST_IDLE);

    mem_route_select #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .MSG_BITS     (MSG_BITS),
        .NODE_BITS    (NODE_BITS),
        .NODE_ID      (NODE_ID)
    ) u_route (
        .req_home       (bus.cache2interface_address[ADDRESS_WIDTH-1 -: NODE_BITS]),
        .req_local      (req_local),
        .sel_local      (local_reg),
        .out_msg        (out_msg),
        .out_address    (out_address),
        .out_data       (out_data),
        .mem_msg        (bus.mem2interface_msg),
        .mem_address    (bus.mem2interface_address),
        .mem_data       (bus.mem2interface_data),
        .net_msg        (bus.network2interface_msg),
        .net_address    (bus.network2interface_address),
        .net_data       (bus.network2interface_data),
        .resp_msg       (resp_msg),
        .resp_address   (resp_address),
        .resp_data      (resp_data),
        .mem_req_msg    (bus.interface2mem_msg),
        .mem_req_address(bus.interface2mem_address),
        .mem_req_data   (bus.interface2mem_data),
        .net_req_msg    (bus.interface2network_msg),
        .net_req_address(bus.interface2network_address),
        .net_req_data   (bus.interface2network_data)
    );

endmodule

// File: tb/tb_mem_line_interface.sv
// Directed bench for mem_line_interface with a queue-based line model checked every cycle.
module tb_mem_line_interface;
    import mem_line_interface_pkg::*;

    localparam int OB = 2, W = 4, DW = 32, AW = 32, MB = 4, LW = W * DW;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_line_interface_if #(.OFFSET_BITS(OB), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MSG_BITS(MB)) bus ();

    mem_line_interface #(
        .OFFSET_BITS(OB), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
        .MSG_BITS(MB), .NODE_BITS(2), .NODE_ID(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memories: unwritten locations return a recognisable address-derived pattern.
    logic [DW-1:0] lmem [logic [AW-1:0]];
    logic [DW-1:0] nmem [logic [AW-1:0]];
    function automatic logic [DW-1:0] lmem_rd(input logic [AW-1:0] a);
        return lmem.exists(a) ? lmem[a] : (32'hC000_0000 | {16'h0, a[15:0]});
    endfunction
    function automatic logic [DW-1:0] nmem_rd(input logic [AW-1:0] a);
        return nmem.exists(a) ? nmem[a] : (32'hE000_0000 | {16'h0, a[15:0]});
    endfunction

    int mem_wait = 0, lw_cnt = 0, nw_cnt = 0, stray_left = 0;

    // Responders: answer in the same cycle when mem_wait is 0.
    initial begin
        bus.mem2interface_msg = '0; bus.mem2interface_address = '0; bus.mem2interface_data = '0;
        bus.network2interface_msg = '0; bus.network2interface_address = '0; bus.network2interface_data = '0;
        forever begin
            @(posedge clock);
            #1;
            bus.mem2interface_msg = '0; bus.mem2interface_address = '0; bus.mem2interface_data = '0;
            bus.network2interface_msg = '0; bus.network2interface_address = '0; bus.network2interface_data = '0;
            if (bus.interface2mem_msg != '0) begin
                if (stray_left > 0) begin
                    if (stray_left > 2) begin
                        bus.mem2interface_msg = MB'(MEM_RESP);
                        bus.mem2interface_address = 32'h99;
                        bus.mem2interface_data = 32'hDEAD_BEEF;
                    end else begin
                        bus.network2interface_msg = MB'(MEM_RESP);
                        bus.network2interface_address = bus.interface2mem_address;
                        bus.network2interface_data = 32'hBAD0_BAD0;
                    end
                    stray_left--;
                end else if (lw_cnt < mem_wait) begin
                    lw_cnt++;
                end else begin
                    lw_cnt = 0;
                    bus.mem2interface_msg = MB'(MEM_RESP);
                    bus.mem2interface_address = bus.interface2mem_address;
                    if (bus.interface2mem_msg == MB'(WB_REQ))
                        lmem[bus.interface2mem_address] = bus.interface2mem_data;
                    else
                        bus.mem2interface_data = lmem_rd(bus.interface2mem_address);
                end
            end
            if (bus.interface2network_msg != '0) begin
                if (nw_cnt < mem_wait) begin
                    nw_cnt++;
                end else begin
                    nw_cnt = 0;
                    bus.network2interface_msg = MB'(MEM_RESP);
                    bus.network2interface_address = bus.interface2network_address;
                    if (bus.interface2network_msg == MB'(WB_REQ))
                        nmem[bus.interface2network_address] = bus.interface2network_data;
                    else
                        bus.network2interface_data = nmem_rd(bus.interface2network_address);
                end
            end
        end
    end

    // Line model: a queue of word offsets still to be transferred.
    int            m_q[$];
    bit            m_active = 0, m_respond = 0, m_read = 0, m_local = 0;
    logic [AW-1:0] m_base = '0, m_caddr = '0;
    logic [DW-1:0] m_wline [W];
    logic [DW-1:0] m_rline [W];
    logic [MB-1:0] m_rm;
    logic [AW-1:0] m_ra;
    logic [DW-1:0] m_rd;
    int            m_st;

    initial begin
        for (int i = 0; i < W; i++) begin m_wline[i] = '0; m_rline[i] = '0; end
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_q.delete(); m_active = 0; m_respond = 0;
                for (int i = 0; i < W; i++) m_rline[i] = '0;
            end else if (m_respond) begin
                m_respond = 0;
            end else if (m_active) begin
                m_rm = m_local ? bus.mem2interface_msg     : bus.network2interface_msg;
                m_ra = m_local ? bus.mem2interface_address : bus.network2interface_address;
                m_rd = m_local ? bus.mem2interface_data    : bus.network2interface_data;
                if (m_rm == MB'(MEM_RESP) && m_ra == (m_base | AW'(m_q[0]))) begin
                    if (m_read) m_rline[m_q[0]] = m_rd;
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin m_active = 0; m_respond = 1; end
                end
            end else if (bus.cache2interface_msg inside {MB'(R_REQ), MB'(WB_REQ), MB'(FLUSH)}) begin
                m_read  = (bus.cache2interface_msg == MB'(R_REQ));
                m_local = (bus.cache2interface_address[AW-1 -: 2] == 2'd0);
                m_base  = bus.cache2interface_address & ~AW'(W - 1);
                m_caddr = bus.cache2interface_address;
                m_st    = 0;
`ifdef CRITICAL_WORD_FIRST_EN
                if (m_read) m_st = int'(bus.cache2interface_address % W);
`endif
                for (int k = 0; k < W; k++) m_q.push_back((m_st + k) % W);
                if (!m_read)
                    for (int k = 0; k < W; k++) m_wline[k] = bus.cache2interface_data[k*DW +: DW];
                m_active = 1;
            end
        end
    end

    // Compare process: every output against the model, every cycle.
    logic [MB-1:0]  e_msg;
    logic [AW-1:0]  e_addr;
    logic [DW-1:0]  e_data;
    logic [LW-1:0]  e_line;
    initial forever begin
        @(negedge clock);
        if (check_en) begin
            e_msg  = m_active ? (m_read ? MB'(R_REQ) : MB'(WB_REQ)) : '0;
            e_addr = m_active ? (m_base | AW'(m_q[0])) : '0;
            e_data = (m_active && !m_read) ? m_wline[m_q[0]] : '0;
            for (int k = 0; k < W; k++) e_line[k*DW +: DW] = m_rline[k];
            chk("mem_msg",  bus.interface2mem_msg,         m_local ? e_msg  : '0);
            chk("mem_addr", bus.interface2mem_address,     m_local ? e_addr : '0);
            chk("mem_data", bus.interface2mem_data,        m_local ? e_data : '0);
            chk("net_msg",  bus.interface2network_msg,     m_local ? '0 : e_msg);
            chk("net_addr", bus.interface2network_address, m_local ? '0 : e_addr);
            chk("net_data", bus.interface2network_data,    m_local ? '0 : e_data);
            chk("cache_msg",  bus.interface2cache_msg,     m_respond ? MB'(MEM_RESP) : '0);
            chk("cache_addr", bus.interface2cache_address, m_respond ? m_caddr : '0);
            chk("cache_data", bus.interface2cache_data,    e_line);
            chk("busy",       bus.interface_busy,          m_active || m_respond);
        end
    end

    // Issue logs and one line per completed cache transaction.
    logic [AW-1:0] mem_log[$], net_log_a[$];
    logic [DW-1:0] net_log_d[$];
    logic [MB-1:0] p_mmsg = '0, p_nmsg = '0;
    logic [AW-1:0] p_maddr = '0, p_naddr = '0;
    initial forever begin
        @(negedge clock);
        if (bus.interface2mem_msg != '0 && (p_mmsg == '0 || bus.interface2mem_address != p_maddr))
            mem_log.push_back(bus.interface2mem_address);
        if (bus.interface2network_msg != '0 && (p_nmsg == '0 || bus.interface2network_address != p_naddr)) begin
            net_log_a.push_back(bus.interface2network_address);
            net_log_d.push_back(bus.interface2network_data);
        end
        p_mmsg = bus.interface2mem_msg;     p_maddr = bus.interface2mem_address;
        p_nmsg = bus.interface2network_msg; p_naddr = bus.interface2network_address;
        if (bus.interface2cache_msg == MB'(MEM_RESP))
            $display("txn done: addr=%h line=%h", bus.interface2cache_address, bus.interface2cache_data);
    end

    task automatic present(input logic [MB-1:0] m, input logic [AW-1:0] a, input logic [LW-1:0] d);
        @(posedge clock); #1;
        bus.cache2interface_msg = m; bus.cache2interface_address = a; bus.cache2interface_data = d;
        @(posedge clock); #1;
        bus.cache2interface_msg = '0;
        bus.cache2interface_data = ~d;
    endtask

    // Returns the cycle (1 = first cycle after acceptance) showing MEM_RESP to the cache.
    task automatic wait_resp(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (bus.interface2cache_msg == MB'(MEM_RESP)) begin cyc = k; break; end
        end
        if (cyc < 0) chk("resp_timeout", 0, 1);
    endtask

    int c;
    int exp_order [W];

    initial begin
        bus.cache2interface_msg = '0; bus.cache2interface_address = '0; bus.cache2interface_data = '0;
        for (int i = 0; i < W; i++) lmem[32'h10 + i] = 32'hA0 + i;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", bus.interface_busy, 0);
        chk("rst_cache_msg", bus.interface2cache_msg, 0);
        chk("rst_cache_data", bus.interface2cache_data, 0);
        chk("rst_mem_msg", bus.interface2mem_msg, 0);
        check_en = 1'b1;
        @(posedge clock); #2 reset = 1'b1;

        // Local read, zero wait
        mem_log.delete();
        present(MB'(R_REQ), 32'h10, '0);
        wait_resp(c);
        chk("rd_latency", c, 5);
        chk("rd_line", bus.interface2cache_data, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("rd_resp_addr", bus.interface2cache_address, 32'h10);
        chk("rd_issue_cnt", mem_log.size(), 4);
        for (int k = 0; k < W; k++) chk($sformatf("rd_order%0d", k), mem_log[k], 32'h10 + k);
        @(negedge clock);
        chk("resp_one_cycle", bus.interface2cache_msg, 0);
        chk("busy_fall", bus.interface_busy, 0);

        // Remote write-back with a held R_REQ during WRITE
        mem_log.delete(); net_log_a.delete(); net_log_d.delete();
        present(MB'(WB_REQ), 32'h4000_0020, 128'h44440003_33330002_22220001_11110000);
        bus.cache2interface_msg = MB'(R_REQ);
        bus.cache2interface_address = 32'h30;
        wait_resp(c);
        chk("wb_latency", c, 5);
        chk("wb_mem_quiet", mem_log.size(), 0);
        chk("wb_issue_cnt", net_log_a.size(), 4);
        for (int k = 0; k < W; k++) begin
            chk($sformatf("wb_addr%0d", k), net_log_a[k], 32'h4000_0020 + k);
            chk($sformatf("wb_data%0d", k), net_log_d[k], (32'h1111_0000 * (k + 1)) + k);
        end
        @(posedge clock); #1;
        chk("idle_after_resp", bus.interface_busy, 0);
        @(posedge clock); #1;
        bus.cache2interface_msg = '0;
        chk("held_req_accepted", bus.interface_busy, 1);
        chk("held_req_addr", bus.interface2mem_address, 32'h30);
        wait_resp(c);
        chk("held_rd_latency", c, 5);
        chk("held_rd_line", bus.interface2cache_data, 128'hC0000033_C0000032_C0000031_C0000030);

        // Offset read with one wait state per word
        mem_log.delete();
        mem_wait = 1;
        present(MB'(R_REQ), 32'h12, '0);
        wait_resp(c);
        mem_wait = 0;
        chk("cwf_latency", c, 9);
        chk("cwf_line", bus.interface2cache_data, 128'h000000A3_000000A2_000000A1_000000A0);
`ifdef CRITICAL_WORD_FIRST_EN
        exp_order = '{32'h12, 32'h13, 32'h10, 32'h11};
`else
        exp_order = '{32'h10, 32'h11, 32'h12, 32'h13};
`endif
        chk("cwf_issue_cnt", mem_log.size(), 4);
        for (int k = 0; k < W; k++) chk($sformatf("cwf_order%0d", k), mem_log[k], exp_order[k]);

        // Stray responses: wrong address, then the unselected port
        mem_log.delete();
        stray_left = 4;
        present(MB'(R_REQ), 32'h50, '0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("stray_hold_addr", bus.interface2mem_address, 32'h50);
        chk("stray_hold_msg", bus.interface2mem_msg, MB'(R_REQ));
        wait_resp(c);
        chk("stray_latency", c, 5);
        chk("stray_line", bus.interface2cache_data, 128'hC0000053_C0000052_C0000051_C0000050);
        chk("stray_issue_cnt", mem_log.size(), 4);

        // Local flush goes out as write-back
        present(MB'(FLUSH), 32'h80, 128'h000000F3_000000F2_000000F1_000000F0);
        wait_resp(c);
        chk("flush_latency", c, 5);
        chk("flush_word2", lmem_rd(32'h82), 32'hF2);

        // Reset mid-transaction after two words
        present(MB'(R_REQ), 32'h60, '0);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("arst_mem_msg", bus.interface2mem_msg, 0);
        chk("arst_mem_addr", bus.interface2mem_address, 0);
        chk("arst_busy", bus.interface_busy, 0);
        chk("arst_cache_msg", bus.interface2cache_msg, 0);
        chk("arst_cache_data", bus.interface2cache_data, 0);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        present(MB'(R_REQ), 32'h70, '0);
        wait_resp(c);
        chk("post_rst_latency", c, 5);
        chk("post_rst_line", bus.interface2cache_data, 128'hC0000073_C0000072_C0000071_C0000070);

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
